// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter.
// Holds the device clock low for an inhibit window, drives the start bit,
// then shifts data, odd parity and stop out on device-clock falling edges,
// samples the device ACK and waits for the bus to return idle.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | lines released, waiting for send
// S_INHIBIT  | host holds clock low for INHIBIT_CYCLES, start bit at the end
// S_SHIFT    | drive data[0..7], parity, stop on falling edges 1..10
// S_ACK      | sample device ACK on falling edge 11
// S_WAITIDLE | wait for clock and data both high, then report done
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 840,
    parameter int TIMEOUT_CYCLES = 105000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] data,
    input  logic       ps2ClockIn,
    input  logic       ps2DataIn,
    output logic       ps2ClockOe,
    output logic       ps2DataOe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SHIFT,
        S_ACK,
        S_WAITIDLE
    } state_t;

    localparam logic [31:0] INH_LAST = 32'(INHIBIT_CYCLES - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;
    logic fall;

    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic        data_oe_q, data_oe_d;
    logic        ack_ok_q, ack_ok_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [31:0] cnt_inc;
    logic        timeout;

    // Two-flop synchronizers plus one history flop for edge detection; idle bus is high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2ClockIn;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2DataIn;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall    = clk_prev_q & ~clk_sync_q;
    assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    assign timeout = (cnt_q >= TO_LAST);

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            shift_q   <= 8'h00;
            parity_q  <= 1'b0;
            bit_idx_q <= 4'd0;
            cnt_q     <= 32'd0;
            data_oe_q <= 1'b0;
            ack_ok_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            data_oe_q <= data_oe_d;
            ack_ok_q  <= ack_ok_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Next-state and datapath updates; timeout wins over any edge in the same cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        data_oe_d = data_oe_q;
        ack_ok_d  = ack_ok_q;
        done_d    = 1'b0;
        error_d   = error_q;

        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (send) begin
                    shift_d  = data;
                    parity_d = ~^data;
                    cnt_d    = 32'd0;
                    error_d  = 1'b0;
                    ack_ok_d = 1'b0;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q >= INH_LAST) begin
                    data_oe_d = 1'b1;
                    bit_idx_d = 4'd0;
                    cnt_d     = 32'd0;
                    state_d   = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SHIFT, S_ACK, S_WAITIDLE: begin
                cnt_d = cnt_inc;
                if (timeout) begin
                    data_oe_d = 1'b0;
                    done_d    = 1'b1;
                    error_d   = 1'b1;
                    state_d   = S_IDLE;
                end else if (state_q == S_SHIFT) begin
                    if (fall) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        if (bit_idx_q < 4'd8) begin
                            data_oe_d = ~shift_q[bit_idx_q[2:0]];
                        end else if (bit_idx_q == 4'd8) begin
                            data_oe_d = ~parity_q;
                        end else begin
                            data_oe_d = 1'b0;
                            state_d   = S_ACK;
                        end
                    end
                end else if (state_q == S_ACK) begin
                    if (fall) begin
                        ack_ok_d = ~dat_sync_q;
                        state_d  = S_WAITIDLE;
                    end
                end else begin
                    if (clk_sync_q && dat_sync_q) begin
                        done_d  = 1'b1;
                        error_d = ~ack_ok_q;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign ps2ClockOe = (state_q == S_INHIBIT);
    assign ps2DataOe  = data_oe_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: a simple PS/2 device model clocks frames,
// captures the line bits and optionally ACKs.
module tb_ps2_tx;

    localparam int INH = 840;
    localparam int TO  = 2000;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       send  = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2ClockIn, ps2DataIn;
    logic       ps2ClockOe, ps2DataOe, busy, done, error;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    int          n;
    int          dc0;
    logic        f, e;
    logic [10:0] bits;

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .send       (send),
        .data       (data),
        .ps2ClockIn (ps2ClockIn),
        .ps2DataIn  (ps2DataIn),
        .ps2ClockOe (ps2ClockOe),
        .ps2DataOe  (ps2DataOe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    // Open-collector bus: a line is low if either side pulls it.
    assign ps2ClockIn = ~(ps2ClockOe | dev_clk_low);
    assign ps2DataIn  = ~(ps2DataOe | dev_data_low);

    always @(negedge clock) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        send = 1'b1;
        data = b;
        @(negedge clock);
        send = 1'b0;
        data = 8'h00;
    endtask

    task automatic wait_inhibit(output int cnt);
        cnt = 0;
        while (ps2ClockOe === 1'b1 && cnt < 5000) begin
            cnt++;
            @(negedge clock);
        end
    endtask

    // One device clock period: 20 cycles low, 20 high; line sampled 5 cycles after the fall.
    task automatic dev_edge(output logic b);
        dev_clk_low = 1'b1;
        repeat (5) @(negedge clock);
        b = ps2DataIn;
        repeat (15) @(negedge clock);
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clock);
    endtask

    task automatic run_frame(input logic ack, input int inject_at, output logic [10:0] fb);
        logic b;
        fb = '0;
        fb[0] = ps2DataIn;
        for (int k = 1; k <= 10; k++) begin
            if (k == inject_at) begin
                send = 1'b1;
                data = 8'h00;
                @(negedge clock);
                send = 1'b0;
                @(negedge clock);
            end
            dev_edge(b);
            fb[k] = b;
        end
        dev_data_low = ack;
        repeat (5) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clock);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(output logic found, output logic err);
        found = 1'b0;
        err   = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                found = 1'b1;
                err   = error;
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_clock_oe", ps2ClockOe, 0);
        check("rst_data_oe", ps2DataOe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // 0xED with ACK
        send_byte(8'hED);
        check("busy_after_send", busy, 1);
        wait_inhibit(n);
        check("inhibit_len_ed", n, 840);
        check("start_bit_oe", ps2DataOe, 1);
        repeat (4) @(negedge clock);
        run_frame(1'b1, 0, bits);
        check("frame_ed", bits, {1'b1, 1'b1, 8'hED, 1'b0});
        wait_done(f, e);
        check("done_ed", f, 1);
        check("error_ed", e, 0);
        @(negedge clock);
        check("done_width_ed", done, 0);
        check("idle_busy_ed", busy, 0);

        // 0x55, no ACK on the 11th edge
        send_byte(8'h55);
        wait_inhibit(n);
        repeat (4) @(negedge clock);
        run_frame(1'b0, 0, bits);
        check("frame_55", bits, {1'b1, 1'b1, 8'h55, 1'b0});
        wait_done(f, e);
        check("done_55", f, 1);
        check("error_55", e, 1);
        @(negedge clock);
        check("error_hold_55", error, 1);

        // 0xF4 with no device: timeout
        send_byte(8'hF4);
        check("error_cleared_on_send", error, 0);
        n = 0;
        while (done !== 1'b1 && n < INH + TO + 100) begin
            @(negedge clock);
            n++;
        end
        check("timeout_cycles_in_window", (n >= INH + TO - 2) && (n <= INH + TO + 2), 1);
        check("timeout_done", done, 1);
        check("timeout_error", error, 1);
        check("timeout_clock_oe", ps2ClockOe, 0);
        check("timeout_data_oe", ps2DataOe, 0);
        @(negedge clock);
        check("timeout_busy", busy, 0);

        // 0xAA with a stray send during data bit 5
        dc0 = done_cnt;
        send_byte(8'hAA);
        wait_inhibit(n);
        repeat (4) @(negedge clock);
        run_frame(1'b1, 6, bits);
        check("frame_aa", bits, {1'b1, 1'b1, 8'hAA, 1'b0});
        wait_done(f, e);
        check("error_aa", e, 0);
        repeat (50) @(negedge clock);
        check("single_done_aa", done_cnt - dc0, 1);
        check("no_second_frame_busy", busy, 0);
        check("no_second_frame_inhibit", ps2ClockOe, 0);

        // Reset at edge 6 of a 0x1C frame
        dc0 = done_cnt;
        send_byte(8'h1C);
        wait_inhibit(n);
        repeat (4) @(negedge clock);
        for (int k = 1; k <= 5; k++) begin
            logic b;
            dev_edge(b);
        end
        dev_clk_low = 1'b1;
        repeat (5) @(negedge clock);
        check("pre_reset_data_oe", ps2DataOe, 1);
        reset = 1'b0;
        #1;
        check("midrst_clock_oe", ps2ClockOe, 0);
        check("midrst_data_oe", ps2DataOe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        repeat (3) @(negedge clock);
        dev_clk_low = 1'b0;
        reset = 1'b1;
        repeat (50) @(negedge clock);
        check("midrst_no_done", done_cnt - dc0, 0);
        check("midrst_idle", busy, 0);

        // 0x01 after reset: parity 0, ACK
        send_byte(8'h01);
        wait_inhibit(n);
        check("inhibit_len_01", n, 840);
        repeat (4) @(negedge clock);
        run_frame(1'b1, 0, bits);
        check("frame_01", bits, {1'b1, 1'b0, 8'h01, 1'b0});
        check("parity_01", bits[9], 0);
        wait_done(f, e);
        check("done_01", f, 1);
        check("error_01", e, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
